rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 25 ++
 rtl/rr_grant_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: state encoding, channel limits and width helpers shared by rr_grant_arbiter and rr_pick
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_e;
  localparam int MIN_CH = 2;
  localparam int MAX_CH = 8;
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
  function automatic int idx_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; the first request above ptr (wrapping) wins
module rr_pick import arb_pkg::*; #(
  parameter int N = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // the requesting channel at the smallest circular distance from ptr+1 wins
  always_comb begin
    int best;
    best = N;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (req[i] && ((i + 2 * N - 1 - int'(ptr)) % N) < best) begin
        best = (i + 2 * N - 1 - int'(ptr)) % N;
        idx = IW'(i);
      end
    valid = best < N;
    onehot = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin grant arbiter with minimum hold and all-red gap; ARB_WAIT_MON_EN adds a sticky starvation flag
module rr_grant_arbiter import arb_pkg::*; #(
  parameter int N_CH     = 2,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 1,
  parameter int WAIT_MAX = 16,
  localparam int IW = idx_w(N_CH),
  localparam int HW = cnt_w(HOLD_CYC),
  localparam int GW = cnt_w(GAP_CYC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt,
  output logic [N_CH-1:0] red,
  output logic            busy,
  output logic [IW-1:0]   gnt_id
`ifdef ARB_WAIT_MON_EN
  ,
  output logic            err_wait
`endif
);
  if (N_CH < MIN_CH || N_CH > MAX_CH || HOLD_CYC < 1 || GAP_CYC < 1 || WAIT_MAX < 1) begin : g_bad_cfg
    $error("rr_grant_arbiter: illegal parameter set");
  end
  state_e          state_q, state_d;
  logic [N_CH-1:0] gnt_q, gnt_d, pend_q, pend_d, arb_set, pick_oh;
  logic [IW-1:0]   id_q, id_d, ptr_q, ptr_d, pick_idx;
  logic [HW-1:0]   hold_q, hold_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            pick_vld, own_req, hold_done, gap_done, take;
  assign arb_set   = pend_q | req;
  assign own_req   = |(req & gnt_q);
  assign hold_done = hold_q >= HW'(HOLD_CYC);
  assign gap_done  = gap_q >= GW'(GAP_CYC);
  rr_pick #(.N(N_CH)) u_pick (
    .req    (arb_set),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );
  // next state: hold the grant, clear for GAP_CYC cycles, arbitrate from IDLE or the last CLEAR cycle
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    id_d = id_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    gap_d = gap_q;
    pend_d = pend_q | (req & ~gnt_q);
    take = 1'b0;
    case (state_q)
      GRANT:
        if (hold_done && (|pend_q || !own_req)) begin
          state_d = CLEAR;
          gnt_d = '0;
          hold_d = '0;
          gap_d = GW'(1);
        end else
          hold_d = hold_done ? hold_q : hold_q + HW'(1);
      CLEAR:
        if (gap_done) begin
          take = 1'b1;
          state_d = IDLE;
          gap_d = '0;
        end else
          gap_d = gap_q + GW'(1);
      default: take = 1'b1;
    endcase
    if (take && pick_vld) begin
      state_d = GRANT;
      gnt_d = pick_oh;
      id_d = pick_idx;
      ptr_d = pick_idx;
      hold_d = HW'(1);
      pend_d = pend_d & ~pick_oh;
    end
  end
  // state registers; reset drops any grant on the same edge and forgets pending requests
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      id_q <= '0;
      ptr_q <= IW'(N_CH - 1);
      pend_q <= '0;
      hold_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
      gap_q <= gap_d;
    end
  assign gnt = gnt_q;
  assign red = ~gnt_q;
  assign busy = |gnt_q;
  assign gnt_id = id_q;
`ifdef ARB_WAIT_MON_EN
  localparam int WW = cnt_w(WAIT_MAX + 1);
  logic [N_CH-1:0][WW-1:0] wait_q, wait_d;
  logic [N_CH-1:0]         over;
  logic                    err_q, err_d;
  for (genvar c = 0; c < N_CH; c++) begin : g_wait
    assign wait_d[c] = !pend_d[c] ? '0 : over[c] ? wait_q[c] : wait_q[c] + WW'(1);
    assign over[c] = wait_q[c] > WW'(WAIT_MAX);
  end
  assign err_d = err_q | (|over);
  // per-channel pending-age counters and the sticky flag, cleared only by reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      wait_q <= '0;
      err_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q <= err_d;
    end
  assign err_wait = err_q;
`endif
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed scenarios plus a per-cycle model comparison for 2- and 4-channel arbiters
module tb_rr_grant_arbiter;
  localparam int H = 2;
  localparam int G = 1;
  typedef struct packed {
    int own;
    int held;
    int gap;
    int ptr;
    int last;
    logic [7:0] pend;
    logic err;
    logic [7:0][7:0] wt;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic live = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] req_a = '0, gnt_a, red_a;
  logic busy_a;
  logic [0:0] id_a;
  logic [3:0] req_b = '0, gnt_b, red_b;
  logic busy_b;
  logic [1:0] id_b;
  mdl_t ma, mb;
`ifdef ARB_WAIT_MON_EN
  logic err_a, err_b, err_c;
  logic [3:0] req_c = '0, gnt_c, red_c;
  logic busy_c;
  logic [1:0] id_c;
  mdl_t mc;
`endif
  always #5 clk = ~clk;
  rr_grant_arbiter #(.N_CH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .red(red_a), .busy(busy_a), .gnt_id(id_a)
`ifdef ARB_WAIT_MON_EN
    , .err_wait(err_a)
`endif
  );
  rr_grant_arbiter #(.N_CH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .red(red_b), .busy(busy_b), .gnt_id(id_b)
`ifdef ARB_WAIT_MON_EN
    , .err_wait(err_b)
`endif
  );
`ifdef ARB_WAIT_MON_EN
  rr_grant_arbiter #(.N_CH(4), .WAIT_MAX(3)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .red(red_c), .busy(busy_c), .gnt_id(id_c),
    .err_wait(err_c)
  );
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mg(input mdl_t m);
    return (m.own >= 0) ? 8'd1 << m.own : 8'd0;
  endfunction
  function automatic mdl_t step(input mdl_t m, input logic [7:0] r, input logic rn, input int n, input int wmax);
    mdl_t x;
    logic [7:0] arb;
    logic [2:0] c;
    x = m;
    if (!rn) begin
      x = '0;
      x.own = -1;
      x.ptr = n - 1;
      return x;
    end
    arb = m.pend | r;
    x.pend = m.pend | (r & ~mg(m));
    for (int i = 0; i < n; i++) if (m.wt[i] > 8'(wmax)) x.err = 1'b1;
    if (m.own >= 0) begin
      c = 3'(m.own);
      if (m.held >= H && (m.pend != 0 || !r[c])) begin
        x.own = -1;
        x.gap = G;
      end else if (m.held < H) x.held = m.held + 1;
    end else if (m.gap > 1) x.gap = m.gap - 1;
    else begin
      x.gap = 0;
      for (int k = 1; k <= n; k++) begin
        c = 3'((m.ptr + k) % n);
        if (x.own < 0 && arb[c]) x.own = (m.ptr + k) % n;
      end
      if (x.own >= 0) begin
        x.ptr = x.own;
        x.last = x.own;
        x.held = 1;
        x.pend = x.pend & ~mg(x);
      end
    end
    for (int i = 0; i < 8; i++) x.wt[i] = x.pend[i] ? m.wt[i] + 8'd1 : 8'd0;
    return x;
  endfunction
  always @(posedge clk) begin
    ma = step(ma, 8'(req_a), rst_n, 2, 16);
    mb = step(mb, 8'(req_b), rst_n, 4, 16);
`ifdef ARB_WAIT_MON_EN
    mc = step(mc, 8'(req_c), rst_n, 4, 3);
`endif
    if (!rst_n) live = 1'b1;
  end
  always @(negedge clk) if (live) begin
    chk("a_gnt", gnt_a, mg(ma));
    chk("a_red", red_a, 2'(~mg(ma)));
    chk("a_busy", busy_a, ma.own >= 0);
    chk("a_id", id_a, ma.last);
    chk("a_onehot", $countones(gnt_a) <= 1, 1);
    chk("b_gnt", gnt_b, mg(mb));
    chk("b_red", red_b, 4'(~mg(mb)));
    chk("b_busy", busy_b, mb.own >= 0);
    chk("b_id", id_b, mb.last);
    chk("b_onehot", $countones(gnt_b) <= 1, 1);
`ifdef ARB_WAIT_MON_EN
    chk("a_err", err_a, ma.err);
    chk("b_err", err_b, mb.err);
    chk("c_gnt", gnt_c, mg(mc));
    chk("c_id", id_c, mc.last);
    chk("c_err", err_c, mc.err);
`endif
  end
  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
`ifdef ARB_WAIT_MON_EN
    req_c = '0;
`endif
    tick(2);
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int exp2[10] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2};
    int exp4[14] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};
    int w[4], mx[4];
    do_reset();
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_red_a", red_a, 2'b11);
    chk("rst_red_b", red_b, 4'b1111);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_id_b", id_b, 0);
    req_a = 2'b01;
    tick();
    req_a = '0;
    chk("s1_c1", gnt_a, 2'b01);
    tick();
    chk("s1_c2", gnt_a, 2'b01);
    tick();
    chk("s1_c3", gnt_a, 2'b00);
    tick();
    chk("s1_idle", gnt_a, 2'b00);
    chk("s1_busy", busy_a, 0);
    chk("s1_id_hold", id_a, 0);
    do_reset();
    req_a = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("s2_seq", gnt_a, exp2[i]);
    end
    req_a = '0;
    tick(6);
    do_reset();
    req_b = 4'b0010;
    tick();
    req_b = '0;
    chk("s3_c1", gnt_b, 4'b0010);
    tick();
    chk("s3_c2", gnt_b, 4'b0010);
    tick();
    chk("s3_clear", gnt_b, 4'b0000);
    req_b = 4'b0100;
    tick();
    req_b = '0;
    chk("s3_after_clear", gnt_b, 4'b0100);
    tick();
    chk("s3_c5", gnt_b, 4'b0100);
    req_b = 4'b1000;
    tick();
    req_b = '0;
    chk("s3_clear2", gnt_b, 4'b0000);
    tick();
    chk("s3_pend_kept", gnt_b, 4'b1000);
    chk("s3_id", id_b, 3);
    tick(4);
    do_reset();
    req_b = 4'hF;
    for (int i = 0; i < 4; i++) begin
      w[i] = 0;
      mx[i] = 0;
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("s4_seq", gnt_b, exp4[i]);
      for (int j = 0; j < 4; j++)
        if (gnt_b[j]) begin
          if (w[j] > mx[j]) mx[j] = w[j];
          w[j] = 0;
        end else w[j]++;
    end
    for (int j = 0; j < 4; j++) chk("s4_wait_bound", mx[j] <= 13, 1);
    chk("s4_wait_ch3", mx[3], 9);
`ifdef ARB_WAIT_MON_EN
    chk("s4_err_b", err_b, 0);
`endif
    req_b = '0;
    tick(6);
    do_reset();
    req_a = 2'b11;
    tick();
    chk("s5_pre", gnt_a, 2'b01);
    rst_n = 1'b0;
    tick();
    chk("s5_gnt", gnt_a, 2'b00);
    chk("s5_red", red_a, 2'b11);
    chk("s5_busy", busy_a, 0);
    chk("s5_id", id_a, 0);
    rst_n = 1'b1;
    req_a = '0;
    tick();
    chk("s5_no_pend", gnt_a, 2'b00);
    tick();
    chk("s5_no_pend2", gnt_a, 2'b00);
    req_a = 2'b11;
    tick();
    chk("s5_first_ch0", gnt_a, 2'b01);
    req_a = '0;
    tick(5);
`ifdef ARB_WAIT_MON_EN
    do_reset();
    chk("s6_err_rst", err_c, 0);
    req_c = 4'hF;
    for (int n = 0; n < 60 && !err_c; n++) tick();
    chk("s6_err_rise", err_c, 1);
    req_c = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s6_err_sticky", err_c, 1);
    end
    rst_n = 1'b0;
    tick();
    chk("s6_err_clr", err_c, 0);
    rst_n = 1'b1;
    tick(2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
